bbuf_pingpong: RTL and testbench

//  Double-banked bias buffer between memory-side write path and systolic array bias read port.

---
 rtl/bbuf_pingpong_if.sv | 57 +++++
 rtl/bbuf_pingpong.sv | 167 ++++++++++++++++
 tb/tb_bbuf_pingpong.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bbuf_pingpong_if.sv
// bbuf_pingpong_if
//   Groups the memory-side write path and the array-side read path of the
//   ping-pong bias buffer into one bundle.
//   Modports:
//     slave  - the buffer itself (bbuf_pingpong)
//     master - the writer/reader pair that drives it
//   Signals:
//     mem_write_req/addr/data, mem_write_ready  write strobe, {entry, group id}, data, ready
//     fill_done                                 fill bank complete, hand it to the array
//     buf_read_req/addr                         read strobe and entry address
//     buf_read_data/valid                       read word (2-cycle latency) and its valid
//     bank_ready                                drain bank holds data, reads accepted
//     drain_done                                array finished with the drain bank
//   Optional macro BBUF_BROADCAST_EN adds mem_write_bcast.
interface bbuf_pingpong_if #(
  parameter int ARRAY_M        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int BUF_ADDR_WIDTH = 10
);
  localparam int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH;
  localparam int BUF_ID_W       = $clog2(ARRAY_M / GROUP_SIZE);
  localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W;

  logic                          mem_write_req;
  logic [MEM_ADDR_WIDTH-1:0]     mem_write_addr;
  logic [MEM_DATA_WIDTH-1:0]     mem_write_data;
  logic                          mem_write_ready;
  logic                          fill_done;
`ifdef BBUF_BROADCAST_EN
  logic                          mem_write_bcast;
`endif
  logic                          buf_read_req;
  logic [BUF_ADDR_WIDTH-1:0]     buf_read_addr;
  logic [ARRAY_M*DATA_WIDTH-1:0] buf_read_data;
  logic                          buf_read_valid;
  logic                          bank_ready;
  logic                          drain_done;

  modport slave (
`ifdef BBUF_BROADCAST_EN
    input  mem_write_bcast,
`endif
    input  mem_write_req, mem_write_addr, mem_write_data, fill_done,
    input  buf_read_req, buf_read_addr, drain_done,
    output mem_write_ready, buf_read_data, buf_read_valid, bank_ready
  );

  modport master (
`ifdef BBUF_BROADCAST_EN
    output mem_write_bcast,
`endif
    output mem_write_req, mem_write_addr, mem_write_data, fill_done,
    output buf_read_req, buf_read_addr, drain_done,
    input  mem_write_ready, buf_read_data, buf_read_valid, bank_ready
  );
endinterface

// File: rtl/bbuf_pingpong.sv
// bbuf_pingpong
//   Double-banked bias buffer. The memory side fills one bank while the
//   systolic array drains the other; ownership swaps on fill_done/drain_done.
//   Each bank holds 2^BUF_ADDR_WIDTH entries of ARRAY_M lanes x DATA_WIDTH.
//   Reads return exactly two cycles after acceptance with buf_read_valid.
//   Ports:
//     clk    clock
//     reset  asynchronous, active-low reset
//     bus    bbuf_pingpong_if.slave (write path, read path, handover pulses)
//   Configuration:
//     BBUF_BROADCAST_EN  when defined, mem_write_bcast copies lane 0 of the
//                        write word into every lane of the addressed entry.
module bbuf_pingpong #(
  parameter int ARRAY_M        = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DATA_WIDTH = 64,
  parameter int BUF_ADDR_WIDTH = 10
) (
  input  logic           clk,
  input  logic           reset,
  bbuf_pingpong_if.slave bus
);
  localparam int GROUP_SIZE     = MEM_DATA_WIDTH / DATA_WIDTH;
  localparam int BUF_ID_W       = $clog2(ARRAY_M / GROUP_SIZE);
  localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W;
  localparam int DEPTH          = 1 << BUF_ADDR_WIDTH;
  localparam int GID_W          = (BUF_ID_W > 0) ? BUF_ID_W : 1;
  localparam int RD_W           = ARRAY_M * DATA_WIDTH;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  bank_state_e [1:0]         state_q, state_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic                      write_ready_q;
  logic                      bank_ready_q;
  logic                      wr_acc, rd_acc;
  logic [BUF_ADDR_WIDTH-1:0] wr_entry;
  logic [GID_W-1:0]          wr_gid;
  logic                      bcast;

  // Bank storage: one packed word of ARRAY_M lanes per entry, two banks.
  logic [ARRAY_M-1:0][DATA_WIDTH-1:0] mem [2][DEPTH];

  // Read pipeline: stage 1 is the RAM read, stage 2 the output register.
  logic [RD_W-1:0] rd_word_q;
  logic            rd_valid_q;
  logic [RD_W-1:0] read_data_q;
  logic            read_valid_q;

  // Handshakes see only registered ready flags, so there is no
  // combinational path from any input to mem_write_ready or bank_ready.
  assign wr_acc   = bus.mem_write_req & write_ready_q;
  assign rd_acc   = bus.buf_read_req & bank_ready_q;
  assign wr_entry = bus.mem_write_addr[MEM_ADDR_WIDTH-1:BUF_ID_W];

  generate
    if (BUF_ID_W > 0) begin : g_gid
      assign wr_gid = bus.mem_write_addr[BUF_ID_W-1:0];
    end else begin : g_no_gid
      // A single lane group: every write covers the whole entry.
      assign wr_gid = '0;
    end
  endgenerate

`ifdef BBUF_BROADCAST_EN
  assign bcast = bus.mem_write_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Bank ownership. The fill bank is only ever EMPTY/FILLING and the drain
  // bank only FULL/DRAINING while active, so the two halves below never act
  // on the same bank in one cycle and fill_done/drain_done compose freely.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (wr_acc && state_q[wr_ptr_q] == EMPTY) begin
      state_d[wr_ptr_q] = FILLING;
    end
    if (bus.fill_done && state_q[wr_ptr_q] inside {EMPTY, FILLING}) begin
      state_d[wr_ptr_q] = FULL;
      wr_ptr_d          = ~wr_ptr_q;
    end

    if (rd_acc && state_q[rd_ptr_q] == FULL) begin
      state_d[rd_ptr_q] = DRAINING;
    end
    if (bus.drain_done && state_q[rd_ptr_q] inside {FULL, DRAINING}) begin
      state_d[rd_ptr_q] = EMPTY;
      rd_ptr_d          = ~rd_ptr_q;
    end
  end

  // Ready flags are registered from next-state so they line up with the
  // bank state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= '{EMPTY, EMPTY};
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      write_ready_q <= 1'b1;
      bank_ready_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      write_ready_q <= state_d[wr_ptr_d] inside {EMPTY, FILLING};
      bank_ready_q  <= state_d[rd_ptr_d] inside {FULL, DRAINING};
    end
  end

  // Write port. Uses the pre-edge wr_ptr, so a write in the same cycle as
  // fill_done lands in the bank being handed over.
  // NOTE: the RAM and its read register have no reset; contents survive
  // reset and only the control/valid path is cleared.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int m = 0; m < ARRAY_M; m++) begin
        if (bcast || int'(wr_gid) == m / GROUP_SIZE) begin
          mem[wr_ptr_q][wr_entry][m] <= bcast
            ? bus.mem_write_data[DATA_WIDTH-1:0]
            : bus.mem_write_data[(m % GROUP_SIZE)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read stage 1: the bank is selected with the pointer at acceptance, so a
  // read alongside drain_done still returns data from the released bank.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      rd_word_q <= mem[rd_ptr_q][bus.buf_read_addr];
    end
  end

  // Read stage 2 and the valid pipeline; data holds while valid is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q   <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
    end else begin
      rd_valid_q   <= rd_acc;
      read_valid_q <= rd_valid_q;
      if (rd_valid_q) begin
        read_data_q <= rd_word_q;
      end
    end
  end

  assign bus.mem_write_ready = write_ready_q;
  assign bus.bank_ready      = bank_ready_q;
  assign bus.buf_read_data   = read_data_q;
  assign bus.buf_read_valid  = read_valid_q;
endmodule

// File: tb/tb_bbuf_pingpong.sv
`timescale 1ns/1ps
module tb_bbuf_pingpong;
`ifdef BBUF_BROADCAST_EN
  localparam int AM = 4;
`else
  localparam int AM = 2;
`endif
  localparam int DW    = 32;
  localparam int MDW   = 64;
  localparam int BAW   = 4;
  localparam int GS    = MDW / DW;
  localparam int NG    = AM / GS;
  localparam int IDW   = $clog2(NG);
  localparam int MAW   = BAW + IDW;
  localparam int DEPTH = 1 << BAW;
  localparam int RW    = AM * DW;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bbuf_pingpong_if #(.ARRAY_M(AM), .DATA_WIDTH(DW), .MEM_DATA_WIDTH(MDW),
                     .BUF_ADDR_WIDTH(BAW)) bus ();

  bbuf_pingpong #(.ARRAY_M(AM), .DATA_WIDTH(DW), .MEM_DATA_WIDTH(MDW),
                  .BUF_ADDR_WIDTH(BAW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: the buffer seen as a two-slot queue of banks.
  // occ = banks handed to the array and not yet released.
  int     occ, fill_bank, drain_bank;
  longint edges = 0;
  logic [RW-1:0] mm    [2][DEPTH];
  logic [AM-1:0] known [2][DEPTH];
  typedef struct { longint due; logic [RW-1:0] data; } pend_t;
  pend_t pend[$];
  logic          exp_valid;
  logic [RW-1:0] exp_data;

  task automatic model_write(int b, logic [MAW-1:0] a, logic [MDW-1:0] d, bit bc);
    int entry, gid;
    entry = int'(a) / NG;
    gid   = int'(a) % NG;
    for (int m = 0; m < AM; m++) begin
      if (bc || m / GS == gid) begin
        mm[b][entry][m*DW +: DW] = bc ? d[DW-1:0] : d[(m % GS)*DW +: DW];
        known[b][entry][m] = 1'b1;
      end
    end
  endtask

  // One clock: sample inputs, advance the model, settle 1ns past the edge.
  task automatic cycle();
    bit wr_ok, rd_ok, f_ok, d_ok, bc;
    logic [RW-1:0]  rword;
    logic [MAW-1:0] wa;
    logic [MDW-1:0] wd;
    wr_ok = bus.mem_write_req && occ < 2;
    rd_ok = bus.buf_read_req && occ > 0;
    f_ok  = bus.fill_done && occ < 2;
    d_ok  = bus.drain_done && occ > 0;
    rword = mm[drain_bank][bus.buf_read_addr];
    wa    = bus.mem_write_addr;
    wd    = bus.mem_write_data;
    bc    = 1'b0;
`ifdef BBUF_BROADCAST_EN
    bc    = bus.mem_write_bcast;
`endif
    @(posedge clk);
    edges++;
    if (rd_ok) pend.push_back('{edges + 1, rword});
    if (wr_ok) model_write(fill_bank, wa, wd, bc);
    if (f_ok) begin occ++; fill_bank ^= 1; end
    if (d_ok) begin occ--; drain_bank ^= 1; end
    #1;
    exp_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == edges) begin
      exp_valid = 1'b1;
      exp_data  = pend[0].data;
      void'(pend.pop_front());
    end
  endtask

  task automatic idle();
    bus.mem_write_req  = 1'b0;
    bus.mem_write_addr = '0;
    bus.mem_write_data = '0;
    bus.fill_done      = 1'b0;
    bus.buf_read_req   = 1'b0;
    bus.buf_read_addr  = '0;
    bus.drain_done     = 1'b0;
`ifdef BBUF_BROADCAST_EN
    bus.mem_write_bcast = 1'b0;
`endif
  endtask

  // Issues one write per lane group so the whole entry is written.
  task automatic write_groups(int entry, logic [RW-1:0] word);
    for (int g = 0; g < NG; g++) begin
      bus.mem_write_req  = 1'b1;
      bus.mem_write_addr = MAW'(entry * NG + g);
      bus.mem_write_data = word[g*MDW +: MDW];
      cycle();
    end
    bus.mem_write_req = 1'b0;
  endtask

  task automatic pulse(bit fd, bit dd);
    bus.fill_done  = fd;
    bus.drain_done = dd;
    cycle();
    bus.fill_done  = 1'b0;
    bus.drain_done = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    reset = 1'b0;
    occ = 0; fill_bank = 0; drain_bank = 0;
    pend.delete();
    exp_valid = 1'b0;
    exp_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  function automatic logic [RW-1:0] rand_word();
    logic [RW-1:0] w;
    for (int g = 0; g < NG; g++) w[g*MDW +: MDW] = {$urandom, $urandom};
    return w;
  endfunction

  task automatic test_reset();
    apply_reset();
    tests++; if (bus.mem_write_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", bus.mem_write_ready); end
    tests++; if (bus.bank_ready !== 1'b0) begin fails++; $display("FAIL reset_bank_ready got %b want 0", bus.bank_ready); end
    tests++; if (bus.buf_read_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.buf_read_valid); end
    tests++; if (bus.buf_read_data !== '0) begin fails++; $display("FAIL reset_data got %h want 0", bus.buf_read_data); end
  endtask

  logic [RW-1:0] word1;

  task automatic test_basic();
    for (int m = 0; m < AM; m++) word1[m*DW +: DW] = DW'(m + 1);
    write_groups(5, word1);
    pulse(1'b1, 1'b0);
    tests++; if (bus.bank_ready !== 1'b1) begin fails++; $display("FAIL basic_bank_ready got %b want 1", bus.bank_ready); end
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(5);
    cycle();
    bus.buf_read_req = 1'b0;
    tests++; if (bus.buf_read_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid got %b want 0", bus.buf_read_valid); end
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got %b want 1", bus.buf_read_valid); end
    tests++; if (bus.buf_read_data !== word1) begin fails++; $display("FAIL basic_data got %h want %h", bus.buf_read_data, word1); end
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b0 || bus.buf_read_data !== word1) begin
      fails++; $display("FAIL basic_hold got v=%b d=%h want v=0 d=%h", bus.buf_read_valid, bus.buf_read_data, word1);
    end
  endtask

  task automatic test_pingpong();
    logic [RW-1:0] wb [4];
    logic [RW-1:0] garbage;
    int k;
    // Fill bank1 while streaming back-to-back reads of bank0 entry 5.
    k = 0;
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(5);
    for (int i = 0; i < 4; i++) begin
      wb[i] = rand_word();
      for (int g = 0; g < NG; g++) begin
        bus.mem_write_req  = 1'b1;
        bus.mem_write_addr = MAW'(i * NG + g);
        bus.mem_write_data = wb[i][g*MDW +: MDW];
        cycle();
        if (k >= 1) begin
          tests++; if (bus.buf_read_valid !== 1'b1 || bus.buf_read_data !== word1) begin
            fails++; $display("FAIL pp_stream k=%0d got v=%b d=%h want v=1 d=%h", k, bus.buf_read_valid, bus.buf_read_data, word1);
          end
        end
        k++;
      end
    end
    idle();
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b1) begin fails++; $display("FAIL pp_last_valid got %b want 1", bus.buf_read_valid); end
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b0) begin fails++; $display("FAIL pp_tail_valid got %b want 0", bus.buf_read_valid); end
    pulse(1'b1, 1'b0);
    tests++; if (bus.mem_write_ready !== 1'b0) begin fails++; $display("FAIL pp_full_ready got %b want 0", bus.mem_write_ready); end
    // Writes while both banks belong to the array must be dropped.
    garbage = rand_word();
    for (int r = 0; r < 3; r++) begin
      write_groups(5, garbage);
      tests++; if (bus.mem_write_ready !== 1'b0) begin fails++; $display("FAIL pp_ready_held r=%0d got %b want 0", r, bus.mem_write_ready); end
    end
    pulse(1'b0, 1'b1);
    tests++; if (bus.mem_write_ready !== 1'b1 || bus.bank_ready !== 1'b1) begin
      fails++; $display("FAIL pp_release got rdy=%b brdy=%b want 1 1", bus.mem_write_ready, bus.bank_ready);
    end
    for (int i = 0; i <= 4; i++) begin
      bus.buf_read_req  = (i < 4);
      bus.buf_read_addr = BAW'(i % 4);
      cycle();
      if (i >= 1) begin
        tests++; if (bus.buf_read_valid !== 1'b1 || bus.buf_read_data !== wb[i-1]) begin
          fails++; $display("FAIL pp_bank1 i=%0d got v=%b d=%h want v=1 d=%h", i - 1, bus.buf_read_valid, bus.buf_read_data, wb[i-1]);
        end
      end
    end
    idle();
    // Refill bank0 elsewhere, swap, and confirm entry 5 kept its data.
    write_groups(6, rand_word());
    pulse(1'b1, 1'b1);
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(5);
    cycle();
    idle();
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b1 || bus.buf_read_data !== word1) begin
      fails++; $display("FAIL pp_dropped_write got v=%b d=%h want v=1 d=%h", bus.buf_read_valid, bus.buf_read_data, word1);
    end
  endtask

  task automatic test_read_not_ready();
    apply_reset();
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(5);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.buf_read_req = 1'b0;
      cycle();
      tests++; if (bus.buf_read_valid !== 1'b0 || bus.bank_ready !== 1'b0) begin
        fails++; $display("FAIL nr_valid i=%0d got v=%b brdy=%b want 0 0", i, bus.buf_read_valid, bus.bank_ready);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [RW-1:0] w0, w1;
    apply_reset();
    w0 = rand_word(); w1 = rand_word();
    write_groups(2, w0);
    pulse(1'b1, 1'b0);
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(2);
    cycle();
    idle();
    cycle(); cycle();
    // Bank0 DRAINING, bank1 FILLING; the last write, a read of the released
    // bank and both pulses all land in the same cycle.
    for (int g = 0; g < NG; g++) begin
      bus.mem_write_req  = 1'b1;
      bus.mem_write_addr = MAW'(7 * NG + g);
      bus.mem_write_data = w1[g*MDW +: MDW];
      if (g == NG - 1) begin
        bus.fill_done = 1'b1; bus.drain_done = 1'b1;
        bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(2);
      end
      cycle();
    end
    idle();
    tests++; if (bus.mem_write_ready !== 1'b1 || bus.bank_ready !== 1'b1) begin
      fails++; $display("FAIL sim_flags got rdy=%b brdy=%b want 1 1", bus.mem_write_ready, bus.bank_ready);
    end
    tests++; if (bus.buf_read_valid !== 1'b0) begin fails++; $display("FAIL sim_early got %b want 0", bus.buf_read_valid); end
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(7);
    cycle();
    idle();
    tests++; if (bus.buf_read_valid !== 1'b1 || bus.buf_read_data !== w0) begin
      fails++; $display("FAIL sim_released got v=%b d=%h want v=1 d=%h", bus.buf_read_valid, bus.buf_read_data, w0);
    end
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b1 || bus.buf_read_data !== w1) begin
      fails++; $display("FAIL sim_bank1 got v=%b d=%h want v=1 d=%h", bus.buf_read_valid, bus.buf_read_data, w1);
    end
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    write_groups(9, rand_word());
    pulse(1'b1, 1'b0);
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(9);
    cycle();
    idle();
    reset = 1'b0;
    occ = 0; fill_bank = 0; drain_bank = 0;
    pend.delete(); exp_valid = 1'b0; exp_data = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if (bus.buf_read_valid !== 1'b0 || bus.bank_ready !== 1'b0 || bus.buf_read_data !== '0) begin
        fails++; $display("FAIL rst_mid i=%0d got v=%b brdy=%b d=%h want 0 0 0", i, bus.buf_read_valid, bus.bank_ready, bus.buf_read_data);
      end
    end
    reset = 1'b1;
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b0) begin fails++; $display("FAIL rst_after got %b want 0", bus.buf_read_valid); end
  endtask

`ifdef BBUF_BROADCAST_EN
  task automatic test_broadcast();
    logic [RW-1:0] want;
    apply_reset();
    for (int m = 0; m < AM; m++) want[m*DW +: DW] = 32'h0000_CAFE;
    bus.mem_write_req   = 1'b1;
    bus.mem_write_bcast = 1'b1;
    bus.mem_write_addr  = MAW'(3 * NG + NG - 1);
    bus.mem_write_data  = {32'hDEAD_BEEF, 32'h0000_CAFE};
    cycle();
    idle();
    pulse(1'b1, 1'b0);
    bus.buf_read_req = 1'b1; bus.buf_read_addr = BAW'(3);
    cycle();
    idle();
    cycle();
    tests++; if (bus.buf_read_valid !== 1'b1 || bus.buf_read_data !== want) begin
      fails++; $display("FAIL bcast got v=%b d=%h want v=1 d=%h", bus.buf_read_valid, bus.buf_read_data, want);
    end
  endtask
`endif

  task automatic test_random();
    logic [BAW-1:0] ra;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      bus.mem_write_req  = ($urandom_range(0, 1) == 1);
      bus.mem_write_addr = MAW'($urandom);
      bus.mem_write_data = {$urandom, $urandom};
`ifdef BBUF_BROADCAST_EN
      bus.mem_write_bcast = ($urandom_range(0, 3) == 0);
`endif
      bus.fill_done  = ($urandom_range(0, 11) == 0);
      bus.drain_done = ($urandom_range(0, 11) == 0);
      ra = BAW'($urandom);
      bus.buf_read_addr = ra;
      bus.buf_read_req  = ($urandom_range(0, 1) == 1);
      // Never read an entry whose lanes the model has not seen written.
      if (occ > 0 && !(&known[drain_bank][ra])) bus.buf_read_req = 1'b0;
      cycle();
      tests++; if (bus.mem_write_ready !== (occ < 2)) begin fails++; $display("FAIL rand_ready c=%0d got %b want %b", c, bus.mem_write_ready, occ < 2); end
      tests++; if (bus.bank_ready !== (occ > 0)) begin fails++; $display("FAIL rand_bank_ready c=%0d got %b want %b", c, bus.bank_ready, occ > 0); end
      tests++; if (bus.buf_read_valid !== exp_valid) begin fails++; $display("FAIL rand_valid c=%0d got %b want %b", c, bus.buf_read_valid, exp_valid); end
      tests++; if (bus.buf_read_data !== exp_data) begin fails++; $display("FAIL rand_data c=%0d got %h want %h", c, bus.buf_read_data, exp_data); end
    end
    idle();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int e = 0; e < DEPTH; e++) known[b][e] = '0;
    idle();
    test_reset();
    test_basic();
    test_pingpong();
    test_read_not_ready();
    test_simultaneous();
    test_reset_mid_read();
`ifdef BBUF_BROADCAST_EN
    test_broadcast();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
